muldiv_arbiter: RTL
===================

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 Parameter NUM_TAGS, default 4, number of in-flight internal tags; 2..2**TRANS_ID_BITS.
REQ-003 Parameter CNT_W, default 32, statistics counter width.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  pipeline flush.
REQ-007 reqN_valid_i  in  1  (N=0,1) requester N presents an operation.
REQ-008 reqN_fu_data_i  in  fu_data_t  requester N operation, operands, trans_id.
REQ-009 reqN_ready_o  out  1  requester N accepted this cycle.
REQ-010 fu_data_o  out  fu_data_t  granted operation; trans_id field replaced by internal tag.
REQ-011 mult_valid_o  out  1  issue strobe to mult unit.
REQ-012 mult_ready_i  in  1  divider can accept; the multiplier always accepts.
REQ-013 mult_valid_i / mult_trans_id_i / result_i  in  1 / TRANS_ID_BITS / XLEN  unit result, tagged.
REQ-014 reqN_res_valid_o / reqN_res_id_o / reqN_res_o  out  1 / TRANS_ID_BITS / XLEN  result routed to owner with original trans_id.
REQ-015 reqN_grant_cnt_o, stall_cnt_o  out  CNT_W  statistics (see Configuration).

Function
REQ-016 Operation is a div-class op when operation is inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW}; all others are mul-class.
REQ-017 Requester N is eligible when valid, a FREE tag exists, flush_i is low, and (mul-class or mult_ready_i high).
REQ-018 Grant is combinational, same cycle: at most one requester granted; reqN_ready_o=1 only for the winner; mult_valid_o=1 iff a grant occurs.
REQ-019 Arbitration is round-robin: when both are eligible, the requester not granted last wins; a 1-bit pointer updates on every grant to the loser; reset value favours req0.
REQ-020 Tag allocation picks the lowest-index FREE tag; on grant that tag records owner, original trans_id, div flag, and moves FREE->BUSY at the next edge.
REQ-021 On mult_valid_i with tag in BUSY: reqOWNER_res_valid_o=1 same cycle with stored trans_id and result_i; other requester's res_valid_o=0; tag BUSY->FREE next edge.
REQ-022 On mult_valid_i with tag in SQUASHED: no res_valid_o; tag SQUASHED->FREE next edge.
REQ-023 A tag freed at an edge is allocatable from the following cycle; return and issue in the same cycle are both honoured.
REQ-024 On flush_i: no grant that cycle; BUSY div tags ->FREE; BUSY mul tags ->SQUASHED; a result arriving in the flush cycle is dropped.
REQ-025 mult_valid_i on a FREE tag is ignored and raises no output.
REQ-026 All-tags-non-FREE: both reqN_ready_o held 0 until a tag frees.

Reset
REQ-027 During reset, all tags FREE, round-robin pointer favours req0, all counters 0, all valid/ready outputs 0.
REQ-028 Reset mid-operation discards all tag state; later results are treated as FREE-tag returns (REQ-025).

Configuration
REQ-029 Macro MULDIV_ARB_STATS_EN compiles in statistics: reqN_grant_cnt_o increment per grant to N; stall_cnt_o increments per cycle with any valid requester but no grant; all counters saturate at all-ones.
REQ-030 Without MULDIV_ARB_STATS_EN, no counter registers exist and statistics outputs are tied to 0.

Structure
REQ-031 Tag state enum (FREE, BUSY, SQUASHED) and tag entry struct (state, owner, trans_id, is_div) reside in ariane_pkg.
REQ-032 Tag storage, allocation and free logic form sub-module muldiv_tag_table; arbitration and routing stay in muldiv_arbiter.

Verification
REQ-033 req0 MUL id 5, req1 DIV id 5 same cycle, mult_ready_i=1 -> req0 granted tag 0; next cycle req1 granted tag 1; results return with ids 5 to correct owners.
REQ-034 Both issuing MUL every cycle for 8 cycles, NUM_TAGS=4, results returned 2 cycles later -> grants alternate 0,1,0,1; no double grant.
REQ-035 4 DIVs outstanding impossible: mult_ready_i=0 after first DIV -> further DIVs stall, MULs from the other requester still granted.
REQ-036 4 MULs in flight, flush_i pulse -> tags SQUASHED; 4 later returns produce no res_valid_o; tags free afterwards; issue resumes.
REQ-037 DIV in flight, flush_i -> tag FREE next cycle, reallocatable immediately.
REQ-038 MULDIV_ARB_STATS_EN set, req0 valid with no free tag for 3 cycles -> stall_cnt_o=3; undefined -> all counters read 0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types for the mul/div arbiter: operation encoding, issue payload and tag table entries.
package ariane_pkg;

   localparam int unsigned XLEN          = config_pkg::cva6_cfg_empty.XLEN;
   localparam int unsigned TRANS_ID_BITS = config_pkg::cva6_cfg_empty.TRANS_ID_BITS;

   typedef enum logic [3:0] {
      MUL, MULH, MULHU, MULHSU, MULW,
      DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
   } fu_op_t;

   typedef struct packed {
      fu_op_t                   operation;
      logic [XLEN-1:0]          operand_a;
      logic [XLEN-1:0]          operand_b;
      logic [XLEN-1:0]          imm;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } fu_data_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      SQUASHED
   } tag_state_e;

   typedef struct packed {
      tag_state_e               state;
      logic                     owner;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic                     is_div;
   } tag_entry_t;

   // The divider is the only unit that can refuse an issue, so only these ops look at mult_ready.
   function automatic logic is_div_op(input fu_op_t op);
      return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
   endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration record for the mul/div arbiter slice.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned TRANS_ID_BITS;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64, TRANS_ID_BITS: 32'd3};

endpackage

// File: rtl/muldiv_tag_table.sv
// Internal tag storage: lowest-free allocation, result lookup, and flush/return bookkeeping.
module muldiv_tag_table
   import ariane_pkg::*;
#(
   parameter int unsigned NUM_TAGS = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     alloc_i,
   input  logic                     alloc_owner_i,
   input  logic [TRANS_ID_BITS-1:0] alloc_trans_id_i,
   input  logic                     alloc_is_div_i,
   input  logic                     ret_valid_i,
   input  logic [TRANS_ID_BITS-1:0] ret_tag_i,
   output logic                     free_avail_o,
   output logic [TRANS_ID_BITS-1:0] free_tag_o,
   output logic                     ret_hit_o,
   output logic                     ret_owner_o,
   output logic [TRANS_ID_BITS-1:0] ret_trans_id_o
);

   tag_entry_t          tags_q [NUM_TAGS];
   tag_entry_t          tags_d [NUM_TAGS];
   logic [NUM_TAGS-1:0] ret_match;

   always_comb begin
      free_avail_o = 1'b0;
      free_tag_o   = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (!free_avail_o && tags_q[i].state == FREE) begin
            free_avail_o = 1'b1;
            free_tag_o   = TRANS_ID_BITS'(i);
         end
      end
   end

   // Any return on a non-free tag retires it; only BUSY tags deliver a result to the owner.
   always_comb begin
      ret_match      = '0;
      ret_hit_o      = 1'b0;
      ret_owner_o    = 1'b0;
      ret_trans_id_o = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (ret_valid_i && ret_tag_i == TRANS_ID_BITS'(i) && tags_q[i].state != FREE) begin
            ret_match[i] = 1'b1;
            if (tags_q[i].state == BUSY) begin
               ret_hit_o      = 1'b1;
               ret_owner_o    = tags_q[i].owner;
               ret_trans_id_o = tags_q[i].trans_id;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++) begin
         tags_d[i] = tags_q[i];
         if (flush_i && tags_q[i].state == BUSY) begin
            tags_d[i].state = tags_q[i].is_div ? FREE : SQUASHED;
         end
         if (ret_match[i]) begin
            tags_d[i].state = FREE;
         end
         if (alloc_i && free_tag_o == TRANS_ID_BITS'(i)) begin
            tags_d[i].state    = BUSY;
            tags_d[i].owner    = alloc_owner_i;
            tags_d[i].trans_id = alloc_trans_id_i;
            tags_d[i].is_div   = alloc_is_div_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            tags_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            tags_q[i] <= tags_d[i];
         end
      end
   end

endmodule

// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for the shared mul/div unit with tag-based result routing.
// Define MULDIV_ARB_STATS_EN to build the saturating grant/stall statistics counters.
module muldiv_arbiter
   import ariane_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
   parameter int unsigned           NUM_TAGS = 4,
   parameter int unsigned           CNT_W    = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic                             req0_valid_i,
   input  fu_data_t                         req0_fu_data_i,
   output logic                             req0_ready_o,
   input  logic                             req1_valid_i,
   input  fu_data_t                         req1_fu_data_i,
   output logic                             req1_ready_o,
   output fu_data_t                         fu_data_o,
   output logic                             mult_valid_o,
   input  logic                             mult_ready_i,
   input  logic                             mult_valid_i,
   input  logic [CVA6Cfg.TRANS_ID_BITS-1:0] mult_trans_id_i,
   input  logic [CVA6Cfg.XLEN-1:0]          result_i,
   output logic                             req0_res_valid_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0] req0_res_id_o,
   output logic [CVA6Cfg.XLEN-1:0]          req0_res_o,
   output logic                             req1_res_valid_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0] req1_res_id_o,
   output logic [CVA6Cfg.XLEN-1:0]          req1_res_o,
   output logic [CNT_W-1:0]                 req0_grant_cnt_o,
   output logic [CNT_W-1:0]                 req1_grant_cnt_o,
   output logic [CNT_W-1:0]                 stall_cnt_o
);

   logic                     rr_q, rr_d;
   logic                     div0, div1;
   logic                     elig0, elig1;
   logic                     grant, win;
   logic                     free_avail;
   logic [TRANS_ID_BITS-1:0] free_tag;
   logic                     ret_hit, ret_owner, res_fire;
   logic [TRANS_ID_BITS-1:0] ret_trans_id;

   // rr_q names the requester that wins a tie; rst_ni gating keeps ready low while reset is held.
   always_comb begin
      div0  = is_div_op(req0_fu_data_i.operation);
      div1  = is_div_op(req1_fu_data_i.operation);
      elig0 = rst_ni & req0_valid_i & free_avail & ~flush_i & (~div0 | mult_ready_i);
      elig1 = rst_ni & req1_valid_i & free_avail & ~flush_i & (~div1 | mult_ready_i);
      grant = elig0 | elig1;
      win   = (elig0 & elig1) ? rr_q : elig1;
      rr_d  = grant ? ~win : rr_q;

      req0_ready_o       = grant & ~win;
      req1_ready_o       = grant & win;
      mult_valid_o       = grant;
      fu_data_o          = win ? req1_fu_data_i : req0_fu_data_i;
      fu_data_o.trans_id = free_tag;
   end

   always_comb begin
      res_fire         = rst_ni & ret_hit & ~flush_i;
      req0_res_valid_o = res_fire & ~ret_owner;
      req1_res_valid_o = res_fire & ret_owner;
      req0_res_id_o    = ret_trans_id;
      req1_res_id_o    = ret_trans_id;
      req0_res_o       = result_i;
      req1_res_o       = result_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   muldiv_tag_table #(
      .NUM_TAGS (NUM_TAGS)
   ) i_tag_table (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .alloc_i          (grant),
      .alloc_owner_i    (win),
      .alloc_trans_id_i (win ? req1_fu_data_i.trans_id : req0_fu_data_i.trans_id),
      .alloc_is_div_i   (win ? div1 : div0),
      .ret_valid_i      (mult_valid_i),
      .ret_tag_i        (mult_trans_id_i),
      .free_avail_o     (free_avail),
      .free_tag_o       (free_tag),
      .ret_hit_o        (ret_hit),
      .ret_owner_o      (ret_owner),
      .ret_trans_id_o   (ret_trans_id)
   );

`ifdef MULDIV_ARB_STATS_EN
   logic [CNT_W-1:0] grant0_cnt_q, grant0_cnt_d;
   logic [CNT_W-1:0] grant1_cnt_q, grant1_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // All counters stick at all-ones rather than wrapping.
   always_comb begin
      grant0_cnt_d = grant0_cnt_q;
      grant1_cnt_d = grant1_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (req0_ready_o && !(&grant0_cnt_q)) begin
         grant0_cnt_d = grant0_cnt_q + CNT_W'(1);
      end
      if (req1_ready_o && !(&grant1_cnt_q)) begin
         grant1_cnt_d = grant1_cnt_q + CNT_W'(1);
      end
      if ((req0_valid_i || req1_valid_i) && !grant && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant0_cnt_q <= '0;
         grant1_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         grant0_cnt_q <= grant0_cnt_d;
         grant1_cnt_q <= grant1_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign req0_grant_cnt_o = grant0_cnt_q;
   assign req1_grant_cnt_o = grant1_cnt_q;
   assign stall_cnt_o      = stall_cnt_q;
`else
   assign req0_grant_cnt_o = '0;
   assign req1_grant_cnt_o = '0;
   assign stall_cnt_o      = '0;
`endif

endmodule
